// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses while holding the CPU in reset.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Start_in,
  input  logic [COUNT_WIDTH-1:0] Word_count_in,
  input  logic [7:0]             Byte_in,
  input  logic                   Byte_valid_in,
  output logic                   Byte_ready_out,
  output logic                   Mem_we_out,
  output logic [31:0]            Mem_addr_out,
  output logic [31:0]            Mem_wdata_out,
  output logic                   Busy_out,
  output logic                   Done_out,
  output logic                   Error_out,
  output logic                   Cpu_rst_out
);

  // state   | meaning
  // IDLE    | waiting for Start_in; Error_out holds its last verdict
  // COLLECT | accepting bytes of the current word
  // WRITE   | single-cycle memory write of the assembled word
  // DONE    | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [COUNT_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]            shift_q, shift_d;
  logic                   error_d;
  logic                   oversize;
  logic                   busy_d;

  assign oversize       = 32'(Word_count_in) > 32'(DEPTH_WORDS);
  assign Byte_ready_out = (state_q == COLLECT);
  assign busy_d         = (state_d == COLLECT) || (state_d == WRITE);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    shift_d    = shift_q;
    error_d    = Error_out;
    case (state_q)
      IDLE: begin
        if (Start_in) begin
          if (Word_count_in == '0) begin
            error_d = 1'b0;
            state_d = DONE;
          end else if (oversize) begin
            error_d = 1'b1;
          end else begin
            error_d    = 1'b0;
            count_d    = Word_count_in;
            word_idx_d = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
            state_d    = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (Byte_valid_in) begin
          shift_d[{byte_cnt_q, 3'b000} +: 8] = Byte_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (word_idx_q + COUNT_WIDTH'(1) == count_q) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + COUNT_WIDTH'(1);
          byte_cnt_d = '0;
          state_d    = COLLECT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      word_idx_q    <= '0;
      count_q       <= '0;
      shift_q       <= '0;
      Mem_we_out    <= 1'b0;
      Mem_addr_out  <= '0;
      Mem_wdata_out <= '0;
      Busy_out      <= 1'b0;
      Cpu_rst_out   <= 1'b0;
      Done_out      <= 1'b0;
      Error_out     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      Mem_we_out  <= (state_d == WRITE);
      Busy_out    <= busy_d;
      Cpu_rst_out <= busy_d;
      Done_out    <= (state_d == DONE);
      Error_out   <= error_d;
      if (state_d == WRITE) begin
        Mem_addr_out  <= 32'(word_idx_q) << 2;
        Mem_wdata_out <= shift_d;
      end
    end
  end

endmodule
